seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1024, clock cycles each digit is driven (legal 1..65535).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, inter-digit blanking cycles (legal 1..255).
REQ-003 HCLK  input  1  system clock; all state updates on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  scan enable; low forces display dark.
REQ-006 seg_data  input  32  four segment bytes; byte k drives digit k; bit0=SegA .. bit6=SegG, bit7=DP.
REQ-007 seg_valid  input  1  seg_data offered this cycle.
REQ-008 seg_ready  output  1  block accepts seg_data this cycle.
REQ-009 SegA,SegB,SegC,SegD,SegE,SegF,SegG,DP  output  1 each  segment lines, copied from the selected byte.
REQ-010 nDigit  output  4  active-low digit selects; bit k selects digit k.
REQ-011 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-012 Two 32-bit registers SHALL exist: pending (plus flag pend_full) and active; only active drives outputs.
REQ-013 seg_ready SHALL equal !pend_full, combinationally.
REQ-014 seg_valid && seg_ready at a rising edge SHALL load pending and set pend_full.
REQ-015 seg_valid with seg_ready low SHALL be ignored; offered data SHALL NOT be lost if master holds it until ready.
REQ-016 FSM states BLANK and DRIVE; 16-bit cycle counter cnt; 2-bit digit index dig.
REQ-017 BLANK: nDigit=4'b1111, all segment outputs 1; after BLANK_CYCLES cycles -> DRIVE, cnt=0.
REQ-018 DRIVE: nDigit = all ones except bit dig = 0; segments = active byte dig; after DWELL_CYCLES cycles -> BLANK, cnt=0, dig=dig+1 mod 4.
REQ-019 Last DRIVE cycle of dig=3 SHALL assert frame_done for exactly that cycle.
REQ-020 At the frame_done edge, if pend_full: active<=pending, pend_full<=0; else active unchanged (no mid-frame tearing).
REQ-021 Accept and frame-boundary transfer in the same edge cannot collide (accept requires pend_full=0); data accepted on the boundary edge SHALL go to pending and display next frame.
REQ-022 Frame length SHALL be 4*(DWELL_CYCLES+BLANK_CYCLES) cycles.
REQ-023 enable low: next edge state=BLANK, dig=0, cnt=0; outputs dark; frame_done=0; if pend_full, active<=pending and pend_full<=0 each edge (immediate update while dark).
REQ-024 enable rising: scan restarts with BLANK period for digit 0.
REQ-025 Outputs SHALL be registered-state decoded only; no combinational path from seg_data to segment outputs.

Reset
REQ-026 HRESETn low SHALL asynchronously set: state=BLANK, cnt=0, dig=0, active=0, pending=0, pend_full=0.
REQ-027 During and after reset until first DRIVE: nDigit=4'b1111, segments all 1, frame_done=0, seg_ready=1.
REQ-028 Reset mid-frame SHALL discard pending data and restart scan at digit 0.

Configuration
REQ-029 Macro SEG7_BLANK_EN SHALL control blanking.
REQ-030 Defined: behaviour per REQ-017..REQ-024.
REQ-031 Undefined: no BLANK state; DRIVE advances directly to next digit; frame length 4*DWELL_CYCLES; after reset/enable, digit 0 driven from first edge; BLANK_CYCLES ignored.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2, SEG7_BLANK_EN defined unless stated)
REQ-032 Reset release, no writes -> cycles 0-1 dark, 2-5 nDigit=1110 segs=0x00, digit order 0,1,2,3, frame_done at cycle 23, period 24.
REQ-033 Write 0x3F06_5B4F mid-frame -> seg_ready drops next cycle; digits keep old values until frame_done; next frame digit0=0x4F, 1=0x5B, 2=0x06, 3=0x3F; seg_ready returns 1 after boundary.
REQ-034 Second write 0x1111_1111 held with seg_valid while pend_full -> not accepted until boundary, then accepted; displayed one frame later; no data lost.
REQ-035 enable low for 10 cycles mid-DRIVE of digit 2 with pending 0xAAAA_AAAA -> nDigit=1111 next cycle, active=0xAAAA_AAAA, rescan starts BLANK digit 0 after enable high.
REQ-036 HRESETn pulse low during digit 3 -> outputs dark, active=0, seg_ready=1 immediately, scan restarts from digit 0.
REQ-037 SEG7_BLANK_EN undefined -> nDigit never 1111 after reset, each digit 4 cycles, frame_done every 16 cycles.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
//   Segment-data handshake between a producer and seg7_scan_driver.
//
//   Handshake: a transfer happens on a rising HCLK edge where seg_valid and
//   seg_ready are both high. The master keeps seg_data stable and seg_valid
//   high until that edge; seg_ready never depends combinationally on
//   seg_valid or seg_data.
//
//   Signals
//     seg_data  [31:0]  four segment bytes, byte k for digit k
//     seg_valid         master offers seg_data this cycle
//     seg_ready         slave can take seg_data this cycle
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
  logic [31:0] seg_data;
  logic        seg_valid;
  logic        seg_ready;

  modport master (
    output seg_data,
    output seg_valid,
    input  seg_ready
  );

  modport slave (
    input  seg_data,
    input  seg_valid,
    output seg_ready
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Multiplexed driver for a four-digit, active-low-select 7-segment display.
//   New frames of segment data arrive through a double buffer (pending ->
//   active). Pending is copied into active only at the end of a full scan,
//   or on every edge while the display is disabled, so a frame never tears.
//
//   Build option: define SEG7_BLANK_EN to insert BLANK_CYCLES of dark time
//   before every digit. Without it each digit follows the previous directly
//   and BLANK_CYCLES has no effect.
//
//   Parameters
//     DWELL_CYCLES  cycles each digit is driven (1..65535)
//     BLANK_CYCLES  dark cycles before each digit (1..255)
//
//   Ports
//     HCLK           clock, rising edge
//     HRESETn        asynchronous active-low reset
//     enable         scan enable; low blanks the display
//     seg_bus        slave side of the segment-data handshake
//     SegA..SegG,DP  segment lines (1 = off when dark)
//     nDigit [3:0]   active-low digit selects
//     frame_done     one-cycle pulse in the last cycle of digit 3
//     dbg_state      current scan state (0 = BLANK, 1 = DRIVE)
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int DWELL_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  enable,
  seg7_scan_driver_if.slave     seg_bus,
  output logic                  SegA,
  output logic                  SegB,
  output logic                  SegC,
  output logic                  SegD,
  output logic                  SegE,
  output logic                  SegF,
  output logic                  SegG,
  output logic                  DP,
  output logic [3:0]            nDigit,
  output logic                  frame_done,
  output logic                  dbg_state
);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // State each digit period begins in: a blank gap when blanking is built in,
  // otherwise straight into driving.
`ifdef SEG7_BLANK_EN
  localparam state_t SCAN_START = ST_BLANK;
`else
  localparam state_t SCAN_START = ST_DRIVE;
`endif

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  // Scan state
  state_t      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [1:0]  dig_q,   dig_d;
  // run_q drops on every disabled edge and keeps the display dark; the first
  // enabled edge afterwards re-arms it while holding the counters at zero so
  // the restarted scan gets a full first period.
  logic        run_q,   run_d;

  // Data buffers
  logic [31:0] pending_q;
  logic [31:0] active_q;
  logic        pend_full_q;

  logic        lit;
  logic        accept;
  logic        xfer;
  logic [7:0]  seg_byte;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= SCAN_START;
      cnt_q   <= 16'd0;
      dig_q   <= 2'd0;
      run_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      run_q   <= run_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    run_d   = run_q;
    if (!enable) begin
      state_d = SCAN_START;
      cnt_d   = 16'd0;
      dig_d   = 2'd0;
      run_d   = 1'b0;
    end else if (!run_q) begin
      run_d   = 1'b1;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_DRIVE;
            cnt_d   = 16'd0;
          end else begin
            cnt_d   = cnt_q + 16'd1;
          end
        end
        ST_DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_d = SCAN_START;
            cnt_d   = 16'd0;
            dig_d   = dig_q + 2'd1;
          end else begin
            cnt_d   = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = SCAN_START;
          cnt_d   = 16'd0;
          dig_d   = 2'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from registered state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    lit        = run_q && (state_q == ST_DRIVE);
    nDigit     = 4'b1111;
    seg_byte   = 8'hFF;
    frame_done = 1'b0;
    if (lit) begin
      nDigit     = ~(4'b0001 << dig_q);
      seg_byte   = active_q[{dig_q, 3'b000} +: 8];
      frame_done = (dig_q == 2'd3) && (cnt_q == DWELL_LAST);
    end
  end

  assign {DP, SegG, SegF, SegE, SegD, SegC, SegB, SegA} = seg_byte;
  assign dbg_state = (state_q == ST_DRIVE);

  // ---------------------------------------------------------------------------
  // Double buffer
  // accept needs an empty pending slot and xfer needs a full one, so the two
  // can never happen on the same edge.
  // ---------------------------------------------------------------------------
  assign seg_bus.seg_ready = !pend_full_q;
  assign accept = seg_bus.seg_valid && !pend_full_q;
  assign xfer   = pend_full_q && (!enable || frame_done);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pending_q   <= 32'd0;
      active_q    <= 32'd0;
      pend_full_q <= 1'b0;
    end else if (accept) begin
      pending_q   <= seg_bus.seg_data;
      pend_full_q <= 1'b1;
    end else if (xfer) begin
      active_q    <= pending_q;
      pend_full_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Bench for seg7_scan_driver with DWELL_CYCLES=4, BLANK_CYCLES=2. Follows
//   SEG7_BLANK_EN the same way as the design. The reference model describes
//   the display as a function of the number of cycles since the scan started.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int D = 4;
`ifdef SEG7_BLANK_EN
  localparam int B = 2;
`else
  localparam int B = 0;
`endif
  localparam int P = 4 * (D + B);

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       enable;
  logic       SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP;
  logic [3:0] nDigit;
  logic       frame_done;
  logic       dbg_state;

  seg7_scan_driver_if bus();

  always #5 HCLK = ~HCLK;

  seg7_scan_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .enable     (enable),
    .seg_bus    (bus),
    .SegA       (SegA),
    .SegB       (SegB),
    .SegC       (SegC),
    .SegD       (SegD),
    .SegE       (SegE),
    .SegF       (SegF),
    .SegG       (SegG),
    .DP         (DP),
    .nDigit     (nDigit),
    .frame_done (frame_done),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_chk = 0;
  int n_err = 0;
  logic [13:0] exp_q[$];   // {seg_ready, frame_done, nDigit, segs}

  // Reference model
  int          m_t;        // cycles since the scan (re)started
  bit          m_hold;     // one dark arming cycle after enable was low
  logic [31:0] m_active;
  logic [31:0] m_pending;
  bit          m_pf;

  function automatic logic [7:0] seg_now();
    return {DP, SegG, SegF, SegE, SegD, SegC, SegB, SegA};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {bus.seg_ready, frame_done, nDigit, seg_now()};
  endfunction

  function automatic logic [13:0] model_out();
    int ph, slot, off;
    logic [3:0] nd;
    logic [7:0] sg;
    logic       fd;
    nd = 4'b1111;
    sg = 8'hFF;
    fd = 1'b0;
    if (!m_hold) begin
      ph   = m_t % P;
      slot = ph / (D + B);
      off  = ph % (D + B);
      if (off >= B) begin
        nd = ~(4'b0001 << slot);
        sg = m_active[slot*8 +: 8];
      end
      fd = (ph == P - 1);
    end
    return {~m_pf, fd, nd, sg};
  endfunction

  function automatic void model_reset();
    m_t       = 0;
    m_hold    = 1'b0;
    m_active  = 32'd0;
    m_pending = 32'd0;
    m_pf      = 1'b0;
  endfunction

  function automatic void model_edge(input logic en, input logic v, input logic [31:0] d);
    logic [13:0] o;
    logic fd;
    o  = model_out();
    fd = o[12];
    if (v && !m_pf) begin
      m_pending = d;
      m_pf      = 1'b1;
    end else if (m_pf && (!en || fd)) begin
      m_active  = m_pending;
      m_pf      = 1'b0;
    end
    if (!en) begin
      m_hold = 1'b1;
      m_t    = 0;
    end else if (m_hold) begin
      m_hold = 1'b0;
      m_t    = 0;
    end else begin
      m_t++;
    end
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (always entered and left just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic step(input logic en, input logic v, input logic [31:0] d, output logic hs);
    logic [13:0] e;
    enable        = en;
    bus.seg_valid = v;
    bus.seg_data  = d;
    if (exp_q.size() == 0) begin
      compare("scoreboard_empty", 32'(0), 32'(1));
    end else begin
      e = exp_q.pop_front();
      compare("cycle", 32'(dut_vec()), 32'(e));
    end
    hs = v && bus.seg_ready;
    model_edge(en, v, d);
    exp_q.push_back(model_out());
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic idle(input int n);
    logic hs;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'd0, hs);
  endtask

  task automatic write_once(input logic [31:0] d, input string name);
    logic hs;
    step(1'b1, 1'b1, d, hs);
    compare(name, 32'(hs), 32'(1));
  endtask

  // Hold seg_valid until the handshake completes; returns cycles spent.
  task automatic write_hold(input logic [31:0] d, output int waited);
    logic hs;
    waited = 0;
    hs = 1'b0;
    while (!hs && waited < 4 * P) begin
      step(1'b1, 1'b1, d, hs);
      waited++;
    end
    compare("hold_handshake", 32'(hs), 32'(1));
  endtask

  task automatic wait_digit(input logic [3:0] pat, input logic [7:0] exp_seg, input string name);
    int n;
    n = 0;
    while (nDigit !== pat && n < 64) begin
      idle(1);
      n++;
    end
    compare(name, 32'({nDigit, seg_now()}), 32'({pat, exp_seg}));
  endtask

  task automatic do_reset();
    logic [13:0] e;
    HRESETn       = 1'b0;
    bus.seg_valid = 1'b0;
    exp_q.delete();
    model_reset();
    e = model_out();
    #1;
    compare("reset_async", 32'(dut_vec()), 32'(e));
    @(posedge HCLK);
    #1;
    compare("reset_hold", 32'(dut_vec()), 32'(e));
    @(negedge HCLK);
    HRESETn = 1'b1;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Test
  // ---------------------------------------------------------------------------
  typedef struct {
    int         t;
    logic [3:0] nd;
    logic [7:0] seg;
    logic       fd;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   tmax;
    int   waited;
    int   n;
    logic hs;

`ifdef SEG7_BLANK_EN
    tbl.push_back('{0,  4'b1111, 8'hFF, 1'b0});
    tbl.push_back('{1,  4'b1111, 8'hFF, 1'b0});
    tbl.push_back('{2,  4'b1110, 8'h00, 1'b0});
    tbl.push_back('{5,  4'b1110, 8'h00, 1'b0});
    tbl.push_back('{6,  4'b1111, 8'hFF, 1'b0});
    tbl.push_back('{8,  4'b1101, 8'h00, 1'b0});
    tbl.push_back('{14, 4'b1011, 8'h00, 1'b0});
    tbl.push_back('{19, 4'b1111, 8'hFF, 1'b0});
    tbl.push_back('{20, 4'b0111, 8'h00, 1'b0});
    tbl.push_back('{23, 4'b0111, 8'h00, 1'b1});
    tbl.push_back('{24, 4'b1111, 8'hFF, 1'b0});
    tbl.push_back('{26, 4'b1110, 8'h00, 1'b0});
    tmax = 26;
`else
    tbl.push_back('{0,  4'b1110, 8'h00, 1'b0});
    tbl.push_back('{3,  4'b1110, 8'h00, 1'b0});
    tbl.push_back('{4,  4'b1101, 8'h00, 1'b0});
    tbl.push_back('{8,  4'b1011, 8'h00, 1'b0});
    tbl.push_back('{12, 4'b0111, 8'h00, 1'b0});
    tbl.push_back('{14, 4'b0111, 8'h00, 1'b0});
    tbl.push_back('{15, 4'b0111, 8'h00, 1'b1});
    tbl.push_back('{16, 4'b1110, 8'h00, 1'b0});
    tmax = 16;
`endif

    HRESETn       = 1'b1;
    enable        = 1'b1;
    bus.seg_valid = 1'b0;
    bus.seg_data  = 32'd0;
    @(negedge HCLK);
    do_reset();

    // First frame timing after reset
    for (int t = 0; t <= tmax; t++) begin
      foreach (tbl[i]) begin
        if (tbl[i].t == t)
          compare($sformatf("first_frame_t%0d", t),
                  32'({frame_done, nDigit, seg_now()}),
                  32'({tbl[i].fd, tbl[i].nd, tbl[i].seg}));
      end
      step(1'b1, 1'b0, 32'd0, hs);
    end

    // Mid-frame write: buffered until the frame boundary
    write_once(32'h3F06_5B4F, "write_a_accept");
    compare("ready_low_after_write", 32'(bus.seg_ready), 32'(0));
    wait_digit(4'b0111, 8'h00, "old_frame_digit3");
    wait_digit(4'b1110, 8'h4F, "new_frame_digit0");
    compare("ready_back_after_boundary", 32'(bus.seg_ready), 32'(1));
    wait_digit(4'b1101, 8'h5B, "new_frame_digit1");
    wait_digit(4'b1011, 8'h06, "new_frame_digit2");
    wait_digit(4'b0111, 8'h3F, "new_frame_digit3");

    // Second write held while pending is full
    write_once(32'h0606_0606, "write_b_accept");
    write_hold(32'h1111_1111, waited);
    compare("held_write_was_blocked", 32'(waited > 1), 32'(1));
    compare("ready_low_after_held", 32'(bus.seg_ready), 32'(0));
    wait_digit(4'b0111, 8'h06, "first_write_shown");
    wait_digit(4'b1110, 8'h11, "held_write_shown");

    // Enable low during digit 2 drive with data pending
    write_once(32'hAAAA_AAAA, "write_aa_accept");
    wait_digit(4'b1011, 8'h11, "digit2_before_disable");
    idle(1);
    step(1'b0, 1'b0, 32'd0, hs);
    compare("dark_after_enable_low", 32'({nDigit, seg_now()}), 32'({4'b1111, 8'hFF}));
    compare("ready_while_dark", 32'(bus.seg_ready), 32'(1));
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'd0, hs);
    n = 0;
    while (nDigit !== 4'b1110 && n < 64) begin
      step(1'b1, 1'b0, 32'd0, hs);
      n++;
    end
    compare("rescan_dark_cycles", 32'(n), 32'(1 + B));
    compare("rescan_digit0_data", 32'({nDigit, seg_now()}), 32'({4'b1110, 8'hAA}));

    // Reset pulse during digit 3 discards pending data
    write_once(32'h1234_5678, "write_pre_reset");
    wait_digit(4'b0111, 8'hAA, "digit3_before_reset");
    idle(1);
    do_reset();
    compare("ready_after_reset", 32'(bus.seg_ready), 32'(1));
    wait_digit(4'b1110, 8'h00, "restart_digit0_cleared");
    wait_digit(4'b1101, 8'h00, "restart_digit1_cleared");
    wait_digit(4'b1110, 8'h00, "pending_discarded");

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) == 0), $urandom, hs);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
